cv32e40p_ex_alu_replica_sched: RTL and testbench

//  Fault-tolerant scheduler for the replicated EX-stage ALUs (4 copies) behind the ID/EX pipeline register.

---
 rtl/cv32e40p_ex_alu_replica_sched_pkg.sv | 52 +++++
 rtl/cv32e40p_ex_alu_replica_sched_if.sv | 26 ++
 rtl/cv32e40p_ex_alu_replica_sched_fault_counter.sv | 48 ++++
 rtl/cv32e40p_ex_alu_replica_sched.sv | 88 ++++++++
 tb/tb_cv32e40p_ex_alu_replica_sched.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/cv32e40p_ex_alu_replica_sched_pkg.sv
// Shared types and helpers for the replicated EX-stage ALU scheduler.
package cv32e40p_ex_alu_replica_sched_pkg;

  typedef enum logic [1:0] {
    FT_TMR     = 2'd0,
    FT_DMR     = 2'd1,
    FT_SIMPLEX = 2'd2,
    FT_FAIL    = 2'd3
  } ft_mode_e;

  localparam int FT_N_ALU      = 4;
  localparam int FT_SEL_BYPASS = 2;

  // Up to three lowest-index healthy replicas form the active set.
  function automatic logic [FT_N_ALU-1:0] ft_pick_active(input logic [FT_N_ALU-1:0] healthy);
    logic [FT_N_ALU-1:0] mask;
    int unsigned         n;
    mask = '0;
    n    = 0;
    for (int i = 0; i < FT_N_ALU; i++) begin
      if (healthy[i] && (n < 3)) begin
        mask[i] = 1'b1;
        n++;
      end
    end
    return mask;
  endfunction

  // Redundancy level that the number of healthy replicas can support.
  function automatic ft_mode_e ft_mode_of(input logic [FT_N_ALU-1:0] healthy);
    int unsigned n;
    n = 0;
    for (int i = 0; i < FT_N_ALU; i++) begin
      if (healthy[i]) n++;
    end
    if (n >= 3)      return FT_TMR;
    else if (n == 2) return FT_DMR;
    else if (n == 1) return FT_SIMPLEX;
    else             return FT_FAIL;
  endfunction

  // Lowest index whose bit equals 'want'; 0 when no bit matches.
  function automatic logic [1:0] ft_first_idx(input logic [FT_N_ALU-1:0] v, input logic want);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = FT_N_ALU - 1; i >= 0; i--) begin
      if (v[i] == want) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/cv32e40p_ex_alu_replica_sched_if.sv
// Issue/vote/control bundle between the pipeline and the replica scheduler.
interface cv32e40p_ex_alu_replica_sched_if;
  import cv32e40p_ex_alu_replica_sched_pkg::*;

  logic       id_valid_i;
  logic       alu_en_id_i;
  logic       vote_valid_i;
  logic [3:0] vote_mismatch_i;
  logic       vote_nomaj_i;
  logic [3:0] clock_enable_alu_o;
  logic [2:0] sel_mux_ex_o;
  ft_mode_e   mode_o;
  logic [3:0] faulty_o;
  logic       retry_o;
  logic       fatal_o;

  modport slave (
    input  id_valid_i, alu_en_id_i, vote_valid_i, vote_mismatch_i, vote_nomaj_i,
    output clock_enable_alu_o, sel_mux_ex_o, mode_o, faulty_o, retry_o, fatal_o
  );

  modport master (
    output id_valid_i, alu_en_id_i, vote_valid_i, vote_mismatch_i, vote_nomaj_i,
    input  clock_enable_alu_o, sel_mux_ex_o, mode_o, faulty_o, retry_o, fatal_o
  );
endinterface

// File: rtl/cv32e40p_ex_alu_replica_sched_fault_counter.sv
// Per-replica leaky fault counter with sticky retirement flag.
module cv32e40p_ex_alu_replica_sched_fault_counter #(
  parameter int unsigned CNT_W        = 4,
  parameter int unsigned FAULT_THRESH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic inc_i,
  input  logic decay_i,
  output logic faulty_o
);

  localparam logic [CNT_W-1:0] THRESH = CNT_W'(FAULT_THRESH);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             faulty_q, faulty_d;
  logic [CNT_W:0]   step;
  logic [CNT_W:0]   sum;

  // Next count: +2 per fault, -1 on decay, net +1 when both; frozen once retired.
  always_comb begin
    cnt_d = cnt_q;
    step  = (inc_i && decay_i) ? (CNT_W+1)'(1) : (CNT_W+1)'(2);
    sum   = {1'b0, cnt_q} + step;
    if (!faulty_q) begin
      if (inc_i) begin
        cnt_d = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
      end else if (decay_i && (cnt_q != '0)) begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
    faulty_d = faulty_q | (cnt_d >= THRESH);
  end

  // Counter and sticky flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      faulty_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      faulty_q <= faulty_d;
    end
  end

  assign faulty_o = faulty_q;

endmodule

// File: rtl/cv32e40p_ex_alu_replica_sched.sv
// Replica scheduler: mode tracking, active-set selection and issue-aligned ALU controls.
module cv32e40p_ex_alu_replica_sched
  import cv32e40p_ex_alu_replica_sched_pkg::*;
#(
  parameter int unsigned CNT_W        = 4,
  parameter int unsigned FAULT_THRESH = 8,
  parameter int unsigned DECAY_W      = 8
) (
  input logic clk,
  input logic rst,
  cv32e40p_ex_alu_replica_sched_if.slave bus
);

  logic [FT_N_ALU-1:0] faulty;
  logic [FT_N_ALU-1:0] healthy;
  logic [FT_N_ALU-1:0] active;
  logic [FT_N_ALU-1:0] inc;
  ft_mode_e            mode_q, mode_d;
  logic [DECAY_W-1:0]  decay_q;
  logic                decay_wrap;
  logic                retry_q, retry_d;
  logic                fatal_q;
  logic [FT_N_ALU-1:0] en_q;
  logic [2:0]          sel_q, sel_d;

  // Active set, fault accounting and retry decision for the current vote.
  always_comb begin
    healthy    = ~faulty;
    active     = ft_pick_active(healthy);
    mode_d     = ft_mode_of(healthy);
    decay_wrap = bus.vote_valid_i && (&decay_q);
    inc        = '0;
    if (bus.vote_valid_i && (mode_q == FT_TMR) && !bus.vote_nomaj_i) begin
      inc = active & bus.vote_mismatch_i;
    end
    retry_d = bus.vote_valid_i &&
              (((mode_q == FT_TMR) && bus.vote_nomaj_i) ||
               ((mode_q == FT_DMR) && (|(bus.vote_mismatch_i & active))));
    // TMR selects the one idle replica as spare; reduced modes select the primary.
    if (mode_q == FT_TMR) begin
      sel_d = {1'b0, ft_first_idx(active, 1'b0)};
    end else begin
      sel_d = {1'b1, ft_first_idx(active, 1'b1)};
    end
  end

  for (genvar g = 0; g < FT_N_ALU; g++) begin : g_cnt
    cv32e40p_ex_alu_replica_sched_fault_counter #(
      .CNT_W       (CNT_W),
      .FAULT_THRESH(FAULT_THRESH)
    ) u_cnt (
      .clk     (clk),
      .rst     (rst),
      .inc_i   (inc[g]),
      .decay_i (decay_wrap),
      .faulty_o(faulty[g])
    );
  end

  // Mode, decay window, status flags and controls latched only on issue.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q  <= FT_TMR;
      decay_q <= '0;
      retry_q <= 1'b0;
      fatal_q <= 1'b0;
      en_q    <= 4'b0111;
      sel_q   <= 3'b011;
    end else begin
      if (mode_d > mode_q) mode_q <= mode_d;
      if (bus.vote_valid_i) decay_q <= decay_q + DECAY_W'(1);
      retry_q <= retry_d;
      fatal_q <= fatal_q | (mode_d == FT_FAIL);
      if (bus.id_valid_i) begin
        en_q  <= bus.alu_en_id_i ? active : '0;
        sel_q <= sel_d;
      end
    end
  end

  assign bus.clock_enable_alu_o = en_q;
  assign bus.sel_mux_ex_o       = sel_q;
  assign bus.mode_o             = mode_q;
  assign bus.faulty_o           = faulty;
  assign bus.retry_o            = retry_q;
  assign bus.fatal_o            = fatal_q;

endmodule

// File: tb/tb_cv32e40p_ex_alu_replica_sched.sv
// Directed self-checking bench for the replica scheduler.
module tb_cv32e40p_ex_alu_replica_sched;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  cv32e40p_ex_alu_replica_sched_if bus();

  cv32e40p_ex_alu_replica_sched #(
    .CNT_W       (4),
    .FAULT_THRESH(8),
    .DECAY_W     (8)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
  endtask

  task automatic vote(input logic [3:0] mm, input logic nomaj, input int n);
    bus.vote_valid_i    = 1'b1;
    bus.vote_mismatch_i = mm;
    bus.vote_nomaj_i    = nomaj;
    tick(n);
    bus.vote_valid_i    = 1'b0;
    bus.vote_mismatch_i = 4'b0000;
    bus.vote_nomaj_i    = 1'b0;
  endtask

  task automatic issue(input logic en);
    bus.id_valid_i  = 1'b1;
    bus.alu_en_id_i = en;
    tick(1);
    bus.id_valid_i  = 1'b0;
    bus.alu_en_id_i = 1'b0;
  endtask

  initial begin
    n_checks            = 0;
    n_errors            = 0;
    rst                 = 1'b1;
    bus.id_valid_i      = 1'b0;
    bus.alu_en_id_i     = 1'b0;
    bus.vote_valid_i    = 1'b0;
    bus.vote_mismatch_i = 4'b0000;
    bus.vote_nomaj_i    = 1'b0;

    // Reset values and basic issue behaviour
    do_reset();
    check("rst_en", int'(bus.clock_enable_alu_o), 'b0111);
    check("rst_sel", int'(bus.sel_mux_ex_o), 'b011);
    check("rst_mode", int'(bus.mode_o), 0);
    check("rst_faulty", int'(bus.faulty_o), 0);
    check("rst_retry", int'(bus.retry_o), 0);
    check("rst_fatal", int'(bus.fatal_o), 0);
    issue(1'b1);
    check("t1_en", int'(bus.clock_enable_alu_o), 'b0111);
    check("t1_sel", int'(bus.sel_mux_ex_o), 'b011);
    check("t1_mode", int'(bus.mode_o), 0);
    issue(1'b0);
    check("t1_en_off", int'(bus.clock_enable_alu_o), 'b0000);
    check("t1_sel_hold", int'(bus.sel_mux_ex_o), 'b011);

    // Replica 1 retired after four mismatching votes; TMR continues with 0,2,3
    do_reset();
    vote(4'b0010, 1'b0, 3);
    check("t2_cnt6_nofault", int'(bus.faulty_o), 0);
    vote(4'b0010, 1'b0, 1);
    check("t2_faulty", int'(bus.faulty_o), 'b0010);
    tick(1);
    check("t2_mode", int'(bus.mode_o), 0);
    issue(1'b1);
    check("t2_en", int'(bus.clock_enable_alu_o), 'b1101);
    check("t2_sel", int'(bus.sel_mux_ex_o), 'b001);

    // Decay wrap without mismatch: 6 -> 5, then +2 -> 7 (healthy), +2 -> 9 (retired)
    do_reset();
    vote(4'b0001, 1'b0, 3);
    vote(4'b0000, 1'b0, 252);
    vote(4'b0000, 1'b0, 1);
    check("t3a_wrap", int'(bus.faulty_o), 0);
    vote(4'b0001, 1'b0, 1);
    check("t3a_cnt7", int'(bus.faulty_o), 0);
    vote(4'b0001, 1'b0, 1);
    check("t3a_cnt9", int'(bus.faulty_o), 'b0001);

    // Mismatch on the wrap vote: 6 -> 7, then +2 -> 9 (retired)
    do_reset();
    vote(4'b0001, 1'b0, 3);
    vote(4'b0000, 1'b0, 252);
    vote(4'b0001, 1'b0, 1);
    check("t3b_wrap_cnt7", int'(bus.faulty_o), 0);
    vote(4'b0001, 1'b0, 1);
    check("t3b_cnt9", int'(bus.faulty_o), 'b0001);

    // Degrade to DMR; mode lags the mask by one cycle; controls wait for an issue
    do_reset();
    vote(4'b0010, 1'b0, 4);
    vote(4'b0100, 1'b0, 4);
    check("t4_faulty", int'(bus.faulty_o), 'b0110);
    check("t4_mode_lag", int'(bus.mode_o), 0);
    tick(1);
    check("t4_mode_dmr", int'(bus.mode_o), 1);
    check("t4_en_noissue", int'(bus.clock_enable_alu_o), 'b0111);
    issue(1'b1);
    check("t4_en", int'(bus.clock_enable_alu_o), 'b1001);
    check("t4_sel", int'(bus.sel_mux_ex_o), 'b100);
    vote(4'b1001, 1'b0, 1);
    check("t4_retry", int'(bus.retry_o), 1);
    tick(1);
    check("t4_retry_end", int'(bus.retry_o), 0);
    vote(4'b1001, 1'b0, 4);
    check("t4_no_count", int'(bus.faulty_o), 'b0110);
    check("t4_mode_hold", int'(bus.mode_o), 1);

    // No majority in TMR: retry only; votes without vote_valid_i are ignored
    do_reset();
    vote(4'b0001, 1'b1, 1);
    check("t5_retry", int'(bus.retry_o), 1);
    check("t5_faulty", int'(bus.faulty_o), 0);
    tick(1);
    check("t5_retry_end", int'(bus.retry_o), 0);
    vote(4'b0001, 1'b1, 4);
    check("t5_no_count", int'(bus.faulty_o), 0);
    tick(1);
    bus.vote_mismatch_i = 4'b1111;
    bus.vote_nomaj_i    = 1'b1;
    tick(5);
    bus.vote_mismatch_i = 4'b0000;
    bus.vote_nomaj_i    = 1'b0;
    check("t5_invalid_faulty", int'(bus.faulty_o), 0);
    check("t5_invalid_retry", int'(bus.retry_o), 0);

    // Retire all replicas: 0 alone, then 1,2,3 together while still in TMR
    do_reset();
    vote(4'b0001, 1'b0, 4);
    check("t6_faulty0", int'(bus.faulty_o), 'b0001);
    vote(4'b1110, 1'b0, 3);
    check("t6_mode_tmr", int'(bus.mode_o), 0);
    vote(4'b1110, 1'b0, 1);
    check("t6_faulty_all", int'(bus.faulty_o), 'b1111);
    tick(1);
    check("t6_mode_fail", int'(bus.mode_o), 3);
    check("t6_fatal", int'(bus.fatal_o), 1);
    issue(1'b1);
    check("t6_en", int'(bus.clock_enable_alu_o), 'b0000);
    check("t6_sel", int'(bus.sel_mux_ex_o), 'b100);
    vote(4'b1111, 1'b1, 1);
    check("t6_retry_fail", int'(bus.retry_o), 0);

    // Reset in the middle of activity
    rst                 = 1'b1;
    bus.vote_valid_i    = 1'b1;
    bus.vote_mismatch_i = 4'b1111;
    bus.id_valid_i      = 1'b1;
    bus.alu_en_id_i     = 1'b1;
    tick(1);
    rst                 = 1'b0;
    bus.vote_valid_i    = 1'b0;
    bus.vote_mismatch_i = 4'b0000;
    bus.id_valid_i      = 1'b0;
    bus.alu_en_id_i     = 1'b0;
    check("t6_rst_en", int'(bus.clock_enable_alu_o), 'b0111);
    check("t6_rst_sel", int'(bus.sel_mux_ex_o), 'b011);
    check("t6_rst_mode", int'(bus.mode_o), 0);
    check("t6_rst_faulty", int'(bus.faulty_o), 0);
    check("t6_rst_retry", int'(bus.retry_o), 0);
    check("t6_rst_fatal", int'(bus.fatal_o), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
